pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Stall and bubble controller for the 5-stage pipe CPU.
- Drives write enables for PC, IF/ID and ID/EXE registers, plus the bubble select for the ID/EXE register.
- Resolves load-use hazards with a one-cycle bubble.
- Freezes the front of the pipe for the fixed latency of the iterative divider while a div instruction sits in EXE.
- Keeps a free-running stall-cycle performance counter.

Parameters:
DIV_CYCLES, 32, number of cycles the pipe stays frozen per div in EXE; legal range 1..63.
CNT_W, 6, width of the divider countdown; must hold DIV_CYCLES-1.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
Drs  in  5  rs field of the instruction in ID
Drt  in  5  rt field of the instruction in ID
Duse_rs  in  1  ID instruction reads rs
Duse_rt  in  1  ID instruction reads rt
Ern  in  5  destination register of the instruction in EXE
Ew_rf  in  1  EXE instruction writes the register file
Eload  in  1  EXE instruction is a load (result available only after MEM)
Ediv  in  1  EXE instruction is a div
pc_wena  out  1  PC register write enable
fd_wena  out  1  IF/ID register write enable
de_wena  out  1  ID/EXE register write enable (drives its wena)
de_bubble  out  1  ID/EXE register captures an all-zero control set (NOP) instead of the ID outputs
div_start  out  1  one-cycle start pulse to the divider
div_busy  out  1  divider countdown in progress
div_done  out  1  release cycle: the div leaves EXE this cycle
stall_cycles  out  32  count of cycles with pc_wena=0

Behaviour:
State machine: RUN, DIV_WAIT. Countdown register cnt[CNT_W-1:0].

Reset (rst=1 at a clock edge):
- state<=RUN, cnt<=0, stall_cycles<=0.
- Reset overrides everything, including mid-countdown.
- While rst=1, combinational outputs are forced: pc_wena=fd_wena=de_wena=1, de_bubble=0, div_start=0, div_busy=0, div_done=0.

Load-use hazard (combinational):
- lu = Eload & Ew_rf & (Ern!=0) & ((Duse_rs & Drs==Ern) | (Duse_rt & Drt==Ern)).

RUN, Ediv=1 (priority over lu):
- div_start=1, pc_wena=fd_wena=de_wena=0, de_bubble=0.
- cnt<=DIV_CYCLES-1, state<=DIV_WAIT.

RUN, Ediv=0, lu=1:
- pc_wena=fd_wena=0, de_wena=1, de_bubble=1. State stays RUN.
- The next cycle sees the bubble in EXE, so lu clears. The stall lasts exactly 1 cycle.

RUN, otherwise:
- All enables 1, de_bubble=0, div_start=0.

DIV_WAIT:
- div_busy=1. Ediv and lu are ignored.
- cnt!=0: all enables 0, cnt<=cnt-1.
- cnt==0: div_done=1, all enables 1, de_bubble=0, state<=RUN. The div advances to MEM and the ID instruction enters EXE.
- If the next instruction is also a div, it is started in the following RUN cycle. There is no back-to-back shortcut.

Timing:
- Frozen cycles per div = DIV_CYCLES, counting the start cycle. The release cycle is start+DIV_CYCLES.
- DIV_CYCLES=1: start cycle, then an immediate release the next cycle.

stall_cycles:
- Increments by 1 at each edge where pc_wena=0 and rst=0.
- Wraps 0xFFFFFFFF->0.

Output timing:
- div_busy is registered-state derived.
- All other outputs are combinational from state, cnt and inputs. No output depends combinationally on de_wena.

Ern=0:
- Never raises lu, since $zero writes are discarded.

Test Plan:
- Reset: hold rst 2 cycles with Ediv=1 -> pc/fd/de_wena=1, div_start=0, stall_cycles=0, state RUN after release.
- Load-use: Eload=1, Ew_rf=1, Ern=5, Drs=5, Duse_rs=1 -> that cycle pc_wena=fd_wena=0, de_wena=1, de_bubble=1. Next cycle (Eload=0) all enables 1. stall_cycles=1.
- No false hazard: same as above but Ern=0, or Duse_rs=0 with Drt=5/Duse_rt=0 -> enables stay 1, de_bubble=0.
- Div, DIV_CYCLES=32: Ediv=1 at cycle 0 -> div_start pulse at cycle 0 only; enables 0 for cycles 0..31; div_busy 1 for cycles 1..32; div_done and enables 1 at cycle 32; stall_cycles=32.
- Div with concurrent lu in ID: Ediv=1 and lu-matching operands -> div path wins (de_bubble=0 throughout); after release, lu evaluated afresh.
- Reset mid-div: assert rst at cycle 10 of countdown -> next cycle state RUN, div_busy=0, cnt=0, stall_cycles=0; a new Ediv=1 restarts a full 32-cycle freeze.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Hazard-control bus between the 5-stage pipe datapath and its stall/bubble controller.
// The pipe (master) supplies ID/EXE fields; the controller (slave) returns enables and divider handshakes.
interface pipe_hazard_if;
    logic [4:0]  Drs;
    logic [4:0]  Drt;
    logic        Duse_rs;
    logic        Duse_rt;
    logic [4:0]  Ern;
    logic        Ew_rf;
    logic        Eload;
    logic        Ediv;
    logic        pc_wena;
    logic        fd_wena;
    logic        de_wena;
    logic        de_bubble;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] stall_cycles;

    modport master (
        output Drs, Drt, Duse_rs, Duse_rt, Ern, Ew_rf, Eload, Ediv,
        input  pc_wena, fd_wena, de_wena, de_bubble, div_start, div_busy, div_done, stall_cycles
    );
    modport slave (
        input  Drs, Drt, Duse_rs, Duse_rt, Ern, Ew_rf, Eload, Ediv,
        output pc_wena, fd_wena, de_wena, de_bubble, div_start, div_busy, div_done, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble controller: one-cycle load-use bubble, fixed-latency freeze for a div in EXE,
// and a free-running count of cycles with the PC held.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic          clk,
    input  logic          rst,
    pipe_hazard_if.slave  hz
);
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] DIV_WAIT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      stall_q;
    logic             lu;
    logic             pc_we, fd_we, de_we, bubble, start, busy, done;

    // $zero is never a real producer, so Ern==0 cannot create a dependency
    assign lu = hz.Eload & hz.Ew_rf & (hz.Ern != 5'd0) &
                ((hz.Duse_rs & (hz.Drs == hz.Ern)) | (hz.Duse_rt & (hz.Drt == hz.Ern)));

    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        de_we     = 1'b1;
        bubble    = 1'b0;
        start     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (hz.Ediv) begin
                        start     = 1'b1;
                        pc_we     = 1'b0;
                        fd_we     = 1'b0;
                        de_we     = 1'b0;
                        cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                        state_nxt = DIV_WAIT;
                    end else if (lu) begin
                        pc_we  = 1'b0;
                        fd_we  = 1'b0;
                        bubble = 1'b1;
                    end
                end
                default: begin
                    busy = 1'b1;
                    if (cnt != '0) begin
                        pc_we   = 1'b0;
                        fd_we   = 1'b0;
                        de_we   = 1'b0;
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        // release: the div moves on to MEM, no back-to-back restart here
                        done      = 1'b1;
                        state_nxt = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            cnt     <= '0;
            stall_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_we)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign hz.pc_wena      = pc_we;
    assign hz.fd_wena      = fd_we;
    assign hz.de_wena      = de_we;
    assign hz.de_bubble    = bubble;
    assign hz.div_start    = start;
    assign hz.div_busy     = busy;
    assign hz.div_done     = done;
    assign hz.stall_cycles = stall_q;
endmodule
